// File: rtl/sdram_readback_seq_if.sv
// Register-port bus between the readback sequencer (master) and the SDRAM handler (slave).
interface sdram_readback_seq_if;
    logic        avalid;
    logic        awe;
    logic        aaddr;
    logic [31:0] adata;
    logic        bvalid;
    logic [31:0] bdata;
    logic        rd_word;

    modport master (
        output avalid, awe, aaddr, adata,
        input  bvalid, bdata, rd_word
    );

    modport slave (
        input  avalid, awe, aaddr, adata,
        output bvalid, bdata, rd_word
    );
endinterface

// File: rtl/sdram_readback_seq.sv
// Splits one readback command into handler-sized chunks, optionally gated on the
// handler's committed-write pointer, and tracks delivered words per chunk.
module sdram_readback_seq #(
    parameter int unsigned CHUNK_MAX = 4095,
    parameter int unsigned POLL_GAP  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [23:0]                 cmd_addr,
    input  logic [23:0]                 cmd_len,
    input  logic                        cmd_wait,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic                        aborted,
    output logic [23:0]                 words_left,
    sdram_readback_seq_if.master        bus
);
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 32;
    localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [AW-1:0] L_CHUNK_MAX = AW'(CHUNK_MAX);
    localparam logic [GW-1:0] L_GAP_LOAD  = GW'(POLL_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_POLL, S_WAIT_STAT, S_GAP, S_SET_ADDR, S_SET_CNT, S_DRAIN, S_ABORT
    } state_t;

    state_t          r_state,      w_nxt_state;
    logic [AW-1:0]   r_cur_addr,   w_nxt_cur_addr;
    logic [AW-1:0]   r_words_left, w_nxt_words_left;
    logic            r_wait_mode,  w_nxt_wait_mode;
    logic [AW-1:0]   r_chunk,      w_nxt_chunk;
    logic [AW-1:0]   r_delivered,  w_nxt_delivered;
    logic [GW-1:0]   r_gap_cnt,    w_nxt_gap_cnt;
    logic            r_done,       w_nxt_done;
    logic            r_aborted,    w_nxt_aborted;
    logic            r_cmd_ready;
    logic            r_busy;
    logic            r_avalid,     w_nxt_avalid;
    logic            r_awe,        w_nxt_awe;
    logic            r_aaddr,      w_nxt_aaddr;
    logic [DW-1:0]   r_adata,      w_nxt_adata;
    logic [AW-1:0]   w_avail;
    logic            w_unused;

    function automatic logic [AW-1:0] min2(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Write-side busy flag and pointer high byte are not needed for gating
    assign w_unused = ^bus.bdata[31:24];
    assign w_avail  = bus.bdata[23:0] - r_cur_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cur_addr   <= '0;
            r_words_left <= '0;
            r_wait_mode  <= 1'b0;
            r_chunk      <= '0;
            r_delivered  <= '0;
            r_gap_cnt    <= '0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_avalid     <= 1'b0;
            r_awe        <= 1'b0;
            r_aaddr      <= 1'b0;
            r_adata      <= '0;
        end else begin
            r_state      <= w_nxt_state;
            r_cur_addr   <= w_nxt_cur_addr;
            r_words_left <= w_nxt_words_left;
            r_wait_mode  <= w_nxt_wait_mode;
            r_chunk      <= w_nxt_chunk;
            r_delivered  <= w_nxt_delivered;
            r_gap_cnt    <= w_nxt_gap_cnt;
            r_done       <= w_nxt_done;
            r_aborted    <= w_nxt_aborted;
            r_cmd_ready  <= (w_nxt_state == S_IDLE);
            r_busy       <= (w_nxt_state != S_IDLE);
            r_avalid     <= w_nxt_avalid;
            r_awe        <= w_nxt_awe;
            r_aaddr      <= w_nxt_aaddr;
            r_adata      <= w_nxt_adata;
        end
    end

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_cur_addr   = r_cur_addr;
        w_nxt_words_left = r_words_left;
        w_nxt_wait_mode  = r_wait_mode;
        w_nxt_chunk      = r_chunk;
        w_nxt_delivered  = r_delivered;
        w_nxt_gap_cnt    = r_gap_cnt;
        w_nxt_done       = 1'b0;
        w_nxt_aborted    = 1'b0;

        if ((r_state != S_IDLE) && bus.rd_word) begin
            if (r_words_left != '0) begin
                w_nxt_words_left = r_words_left - AW'(1);
            end
            w_nxt_delivered = r_delivered + AW'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_nxt_cur_addr   = cmd_addr;
                    w_nxt_words_left = cmd_len;
                    w_nxt_wait_mode  = cmd_wait;
                    if (cmd_len == '0) begin
                        w_nxt_done = 1'b1;
                    end else if (cmd_wait) begin
                        w_nxt_state = S_POLL;
                    end else begin
                        w_nxt_state = S_SET_ADDR;
                        w_nxt_chunk = min2(cmd_len, L_CHUNK_MAX);
                    end
                end
            end
            S_POLL: w_nxt_state = S_WAIT_STAT;
            S_WAIT_STAT: begin
                if (bus.bvalid) begin
                    if (w_avail == '0) begin
                        w_nxt_state   = S_GAP;
                        w_nxt_gap_cnt = L_GAP_LOAD;
                    end else begin
                        w_nxt_state = S_SET_ADDR;
                        w_nxt_chunk = min2(min2(r_words_left, L_CHUNK_MAX), w_avail);
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_nxt_state = S_POLL;
                end else begin
                    w_nxt_gap_cnt = r_gap_cnt - GW'(1);
                end
            end
            S_SET_ADDR: begin
                w_nxt_delivered = '0;
                w_nxt_state     = S_SET_CNT;
            end
            S_SET_CNT: w_nxt_state = S_DRAIN;
            S_DRAIN: begin
                if (r_delivered >= r_chunk) begin
                    w_nxt_cur_addr = r_cur_addr + r_chunk;
                    if (r_words_left == '0) begin
                        w_nxt_state = S_IDLE;
                        w_nxt_done  = 1'b1;
                    end else if (r_wait_mode) begin
                        w_nxt_state = S_POLL;
                    end else begin
                        w_nxt_state = S_SET_ADDR;
                        w_nxt_chunk = min2(r_words_left, L_CHUNK_MAX);
                    end
                end
            end
            S_ABORT: begin
                w_nxt_state   = S_IDLE;
                w_nxt_aborted = 1'b1;
            end
            default: w_nxt_state = S_IDLE;
        endcase

        // Abort wins over every other transition; an abort already in flight just completes
        if (abort && (r_state != S_IDLE) && (r_state != S_ABORT)) begin
            w_nxt_state = S_ABORT;
            w_nxt_done  = 1'b0;
        end
    end

    // Bus request for the state being entered, so it is registered and aligned with that state
    always_comb begin
        w_nxt_avalid = 1'b0;
        w_nxt_awe    = 1'b0;
        w_nxt_aaddr  = 1'b0;
        w_nxt_adata  = '0;
        case (w_nxt_state)
            S_POLL: w_nxt_avalid = 1'b1;
            S_SET_ADDR: begin
                w_nxt_avalid = 1'b1;
                w_nxt_awe    = 1'b1;
                w_nxt_adata  = DW'(w_nxt_cur_addr);
            end
            S_SET_CNT: begin
                w_nxt_avalid = 1'b1;
                w_nxt_awe    = 1'b1;
                w_nxt_aaddr  = 1'b1;
                w_nxt_adata  = DW'(w_nxt_chunk);
            end
            S_ABORT: begin
                w_nxt_avalid = 1'b1;
                w_nxt_awe    = 1'b1;
                w_nxt_aaddr  = 1'b1;
            end
            default: ;
        endcase
    end

    assign cmd_ready  = r_cmd_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign aborted    = r_aborted;
    assign words_left = r_words_left;
    assign bus.avalid = r_avalid;
    assign bus.awe    = r_awe;
    assign bus.aaddr  = r_aaddr;
    assign bus.adata  = r_adata;
endmodule

// File: tb/tb_sdram_readback_seq.sv
// Scoreboard bench for sdram_readback_seq with a small behavioural SDRAM-handler model.
module tb_sdram_readback_seq;
    localparam int unsigned CHUNK_MAX = 4095;
    localparam int unsigned POLL_GAP  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_addr;
    logic [23:0] cmd_len;
    logic        cmd_wait;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [23:0] words_left;

    sdram_readback_seq_if bus ();

    sdram_readback_seq #(.CHUNK_MAX(CHUNK_MAX), .POLL_GAP(POLL_GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_wait   (cmd_wait),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .words_left (words_left),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [34:0] exp_q[$];
    int          rd_cyc[$];
    int          cyc      = 0;
    int          last_w0  = 0;
    int          n_done   = 0;
    int          n_ab     = 0;

    // Handler model state (handler process writes these; main only reads them)
    int          n_reads  = 0;
    int          rd_total = 0;
    int          pending  = 0;
    // Handler configuration (main writes these)
    logic [23:0] ptr_tab[4];
    int          ptr_n;
    int          ptr_first;
    int          rd_limit;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] ev(input logic awe, input logic aaddr, input logic [31:0] d);
        return {1'b1, awe, aaddr, d};
    endfunction

    // One clock: sample at the falling edge, score any bus request against the expected queue
    task automatic tick();
        logic [34:0] obs;
        logic [34:0] ex;
        @(negedge clk);
        cyc++;
        n_done += int'(done);
        n_ab   += int'(aborted);
        if (bus.avalid) begin
            obs = {1'b1, bus.awe, bus.aaddr, bus.adata};
            ex  = '0;
            if (exp_q.size() != 0) ex = exp_q.pop_front();
            check_eq("bus", 64'(obs), 64'(ex));
            if (!bus.awe) rd_cyc.push_back(cyc);
            else if (!bus.aaddr) last_w0 = cyc;
            else if (bus.adata != 32'd0) check_eq("cnt_after_addr", 64'(cyc - last_w0), 64'd1);
        end
    endtask

    task automatic run_cmd(input logic [23:0] a, input logic [23:0] l, input logic w);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_wait  = w;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int base;
        base = n_done + n_ab;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (n_done + n_ab != base) break;
        end
    endtask

    // Handler model: status reply one cycle after a read, rd_word stream after an rcount write
    initial begin
        logic        h_rd;
        logic        h_cnt;
        int          h_cnt_v;
        int          idx;
        bus.bvalid  = 1'b0;
        bus.bdata   = '0;
        bus.rd_word = 1'b0;
        forever begin
            @(negedge clk);
            h_rd    = bus.avalid && !bus.awe;
            h_cnt   = bus.avalid && bus.awe && bus.aaddr;
            h_cnt_v = int'(bus.adata);
            @(posedge clk);
            #1;
            bus.bvalid = h_rd;
            bus.bdata  = '0;
            if (h_rd) begin
                idx = n_reads - ptr_first;
                if (idx >= ptr_n) idx = ptr_n - 1;
                bus.bdata = {8'h00, ptr_tab[idx]};
                n_reads++;
            end
            if (h_cnt) pending = h_cnt_v;
            if (pending > 0 && rd_total < rd_limit) begin
                bus.rd_word = 1'b1;
                pending--;
                rd_total++;
            end else begin
                bus.rd_word = 1'b0;
            end
        end
    end

    initial begin
        int d;
        int t;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_wait  = 1'b0;
        abort     = 1'b0;
        ptr_tab   = '{24'h0, 24'h0, 24'h0, 24'h0};
        ptr_n     = 1;
        ptr_first = 0;
        rd_limit  = 1 << 30;

        repeat (3) tick();
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_aborted", 64'(aborted), 64'd0);
        check_eq("rst_words_left", 64'(words_left), 64'd0);
        check_eq("rst_avalid", 64'(bus.avalid), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single short chunk
        exp_q.push_back(ev(1'b1, 1'b0, 32'h100));
        exp_q.push_back(ev(1'b1, 1'b1, 32'd10));
        d = n_done;
        t = rd_total;
        run_cmd(24'h000100, 24'd10, 1'b0);
        wait_end(200);
        check_eq("t1_done", 64'(n_done), 64'(d + 1));
        check_eq("t1_words", 64'(rd_total - t), 64'd10);
        check_eq("t1_words_left", 64'(words_left), 64'd0);
        check_eq("t1_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (5) tick();
        check_eq("t1_done_once", 64'(n_done), 64'(d + 1));

        // Three chunks limited by CHUNK_MAX
        exp_q.push_back(ev(1'b1, 1'b0, 32'h0));
        exp_q.push_back(ev(1'b1, 1'b1, 32'd4095));
        exp_q.push_back(ev(1'b1, 1'b0, 32'hFFF));
        exp_q.push_back(ev(1'b1, 1'b1, 32'd4095));
        exp_q.push_back(ev(1'b1, 1'b0, 32'h1FFE));
        exp_q.push_back(ev(1'b1, 1'b1, 32'd810));
        d = n_done;
        t = rd_total;
        run_cmd(24'h000000, 24'd9000, 1'b0);
        wait_end(12000);
        check_eq("t2_done", 64'(n_done), 64'(d + 1));
        check_eq("t2_words_at_done", 64'(rd_total - t), 64'd9000);
        check_eq("t2_words_left", 64'(words_left), 64'd0);

        // Pointer-gated: empty poll, gap, two chunks
        ptr_tab   = '{24'h20, 24'h40, 24'h40, 24'h52};
        ptr_n     = 4;
        ptr_first = n_reads;
        rd_cyc.delete();
        exp_q.push_back(ev(1'b0, 1'b0, 32'h0));
        exp_q.push_back(ev(1'b0, 1'b0, 32'h0));
        exp_q.push_back(ev(1'b1, 1'b0, 32'h20));
        exp_q.push_back(ev(1'b1, 1'b1, 32'd32));
        exp_q.push_back(ev(1'b0, 1'b0, 32'h0));
        exp_q.push_back(ev(1'b0, 1'b0, 32'h0));
        exp_q.push_back(ev(1'b1, 1'b0, 32'h40));
        exp_q.push_back(ev(1'b1, 1'b1, 32'd18));
        d = n_done;
        run_cmd(24'h000020, 24'd50, 1'b1);
        wait_end(500);
        check_eq("t3_done", 64'(n_done), 64'(d + 1));
        check_eq("t3_words_left", 64'(words_left), 64'd0);
        check_eq("t3_reads", 64'(rd_cyc.size()), 64'd4);
        if (rd_cyc.size() >= 2)
            check_eq("t3_poll_gap", 64'(rd_cyc[1] - rd_cyc[0]), 64'(2 + POLL_GAP));

        // Pointer arithmetic across the 24-bit wrap
        ptr_tab[0] = 24'h000010;
        ptr_n      = 1;
        ptr_first  = n_reads;
        exp_q.push_back(ev(1'b0, 1'b0, 32'h0));
        exp_q.push_back(ev(1'b1, 1'b0, 32'hFFFFF0));
        exp_q.push_back(ev(1'b1, 1'b1, 32'd32));
        d = n_done;
        run_cmd(24'hFFFFF0, 24'd32, 1'b1);
        wait_end(200);
        check_eq("t4_done", 64'(n_done), 64'(d + 1));
        check_eq("t4_cur_addr", 64'(dut.r_cur_addr), 64'h10);

        // Abort in DRAIN after 5 of 20 words
        rd_limit = rd_total + 5;
        exp_q.push_back(ev(1'b1, 1'b0, 32'h300));
        exp_q.push_back(ev(1'b1, 1'b1, 32'd20));
        exp_q.push_back(ev(1'b1, 1'b1, 32'd0));
        d = n_done;
        t = n_ab;
        run_cmd(24'h000300, 24'd20, 1'b0);
        for (int k = 0; k < 200 && rd_total < rd_limit; k++) tick();
        repeat (2) tick();
        check_eq("t5_busy_before", 64'(busy), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_end(20);
        check_eq("t5_aborted", 64'(n_ab), 64'(t + 1));
        check_eq("t5_no_done", 64'(n_done), 64'(d));
        check_eq("t5_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("t5_words_left", 64'(words_left), 64'd15);
        rd_limit = 1 << 30;
        repeat (3) tick();

        // Empty command
        d = n_done;
        run_cmd(24'h000600, 24'd0, 1'b0);
        repeat (3) tick();
        check_eq("t6_done", 64'(n_done), 64'(d + 1));
        check_eq("t6_busy", 64'(busy), 64'd0);

        // Reset while in SET_CNT, then a fresh command
        exp_q.push_back(ev(1'b1, 1'b0, 32'h400));
        exp_q.push_back(ev(1'b1, 1'b1, 32'd8));
        d = n_done;
        run_cmd(24'h000400, 24'd8, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        check_eq("t7_avalid", 64'(bus.avalid), 64'd0);
        check_eq("t7_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("t7_busy", 64'(busy), 64'd0);
        check_eq("t7_words_left", 64'(words_left), 64'd0);
        repeat (10) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check_eq("t7_no_done", 64'(n_done), 64'(d));
        exp_q.push_back(ev(1'b1, 1'b0, 32'h500));
        exp_q.push_back(ev(1'b1, 1'b1, 32'd10));
        run_cmd(24'h000500, 24'd10, 1'b0);
        wait_end(200);
        check_eq("t7_done_after", 64'(n_done), 64'(d + 1));
        check_eq("t7_words_left_after", 64'(words_left), 64'd0);

        repeat (3) tick();
        check_eq("bus_missing", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/sdram_readback_seq.md
Name: sdram_readback_seq

Overview:
- Host-side initiator for the SDRAM handler's register port (avalid/awe/aaddr/adata -> bvalid/bdata).
- Takes one readback command (start word address, word count) and splits it into chunks of at most CHUNK_MAX words.
- With cmd_wait set, polls the handler's committed-write pointer so reads never overtake data not yet written to SDRAM.
- Programs raddr/rcount for each chunk, then counts delivered words (rd_word) before moving to the next chunk.

Parameters:
CHUNK_MAX, 4095, maximum words per rcount write (handler rcount is 12 bits; legal range 1..4095)
POLL_GAP, 16, idle cycles between status polls when not enough data is committed (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
cmd_addr  in  24  start word address
cmd_len  in  24  word count; 0 = empty command
cmd_wait  in  1  1 = gate each chunk on committed-write pointer
abort  in  1  cancel current command
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: command completed
aborted  out  1  one-cycle pulse: command cancelled
words_left  out  24  words of the command not yet delivered
avalid  out  1  bus request, single-cycle, no backpressure
awe  out  1  1 = register write, 0 = status read
aaddr  out  1  register select: 0 = raddr, 1 = rcount
adata  out  32  write data, zero-extended
bvalid  in  1  status response, exactly one cycle after avalid
bdata  in  32  [31] write-side busy, [23:0] committed write pointer
rd_word  in  1  one pulse per word pushed into the read FIFO (handler r_en)

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; all outputs 0 except cmd_ready=1; internal counters cleared. No bus write is issued on reset. The handler's rcount is not cleared by this block.
- State IDLE:
  - On accept, latch cur_addr=cmd_addr, words_left=cmd_len, wait_mode=cmd_wait.
  - cmd_len=0: pulse done on the next cycle and stay in IDLE.
  - Otherwise: if wait_mode go to POLL, else go to SET_ADDR with chunk=min(words_left, CHUNK_MAX).
- POLL: drive avalid=1, awe=0 for one cycle, then go to WAIT_STAT.
- WAIT_STAT:
  - On bvalid, compute avail = bdata[23:0] - cur_addr (24-bit modular).
  - avail=0: go to GAP.
  - avail!=0: chunk = min(words_left, CHUNK_MAX, avail), then go to SET_ADDR.
  - A bvalid arriving in any other state is ignored.
- GAP: wait POLL_GAP cycles, then go to POLL. Polling continues indefinitely; only abort exits.
- SET_ADDR:
  - Drive avalid=1, awe=1, aaddr=0, adata={8'b0,cur_addr}.
  - Clear delivered counter.
  - Go to SET_CNT.
- SET_CNT: drive avalid=1, awe=1, aaddr=1, adata=chunk, then go to DRAIN. Bus requests are therefore back-to-back: address write first, count write next.
- rd_word handling:
  - Counted in every non-IDLE state.
  - Each pulse decrements words_left; words_left saturates at 0.
  - rd_word in IDLE is ignored.
- DRAIN:
  - When delivered==chunk: cur_addr += chunk (mod 2^24).
  - words_left=0: go to IDLE and pulse done.
  - Otherwise: go to POLL (wait_mode) or SET_ADDR (computing the next chunk).
- abort (non-IDLE): abort has priority over all transitions in that cycle.
  - Next cycle go to ABORT: avalid=1, awe=1, aaddr=1, adata=0 (clears handler rcount).
  - Then go to IDLE; aborted pulses in the same cycle that state returns to IDLE.
  - words_left holds its value until the next accept.
  - abort in IDLE has no effect.
- Bus rules:
  - At most one avalid per cycle.
  - awe/aaddr/adata are don't-care when avalid=0 and are driven as 0.
  - No new status read is issued while a response is pending.
- Wrap: cur_addr wraps 0xFFFFFF -> 0x000000 with no special case.

Test Plan:
- cmd_addr=0x000100, cmd_len=10, cmd_wait=0 -> writes raddr=0x100 then rcount=10 on consecutive cycles; after 10 rd_word pulses, done pulses once, words_left=0.
- cmd_len=9000, cmd_wait=0, CHUNK_MAX=4095 -> chunks 4095/4095/810 at raddr 0x0, 0xFFF, 0x1FFE; done only after the 9000th rd_word.
- cmd_addr=0x20, cmd_len=50, cmd_wait=1, bdata[23:0]=0x20 then 0x40 -> read, POLL_GAP idle cycles, read, then rcount=32 at raddr 0x20; second chunk gated on a pointer >=0x52.
- cmd_addr=0xFFFFF0, cmd_len=32, cmd_wait=1, bdata pointer=0x000010 -> avail=32, single chunk, raddr=0xFFFFF0; cur_addr ends at 0x000010.
- abort in DRAIN after 5 of 20 words -> next cycle rcount=0 write; aborted pulses; done never pulses; cmd_ready=1 afterwards; words_left=15.
- rst_n low during SET_CNT -> no further avalid; outputs at reset values; a new command afterwards runs normally. Also cmd_len=0 -> done pulses with no bus traffic.
